// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signals shared between two requesters, the arbiter and one ALU.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int SHAMT_WIDTH = 5
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [OP_WIDTH-1:0]    req0_op;
    logic [DATA_WIDTH-1:0]  req0_a;
    logic [DATA_WIDTH-1:0]  req0_b;
    logic [SHAMT_WIDTH-1:0] req0_shamt;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [OP_WIDTH-1:0]    req1_op;
    logic [DATA_WIDTH-1:0]  req1_a;
    logic [DATA_WIDTH-1:0]  req1_b;
    logic [SHAMT_WIDTH-1:0] req1_shamt;

    logic [OP_WIDTH-1:0]    alu_op;
    logic [DATA_WIDTH-1:0]  alu_a;
    logic [DATA_WIDTH-1:0]  alu_b;
    logic [SHAMT_WIDTH-1:0] alu_shamt;
    logic [DATA_WIDTH-1:0]  alu_result;
    logic                   alu_zero;

    logic                   rsp0_valid;
    logic                   rsp0_ready;
    logic                   rsp1_valid;
    logic                   rsp1_ready;
    logic [DATA_WIDTH-1:0]  rsp_result;
    logic                   rsp_zero;
    logic                   rsp_err;
    logic                   busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
        input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
        input  alu_result, alu_zero, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b, alu_shamt,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
        output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
        output alu_result, alu_zero, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b, alu_shamt,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// registered operand drive, result/zero capture and illegal-opcode flagging.
module alu_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                 state, next_state;
    logic                   rr_ptr;
    logic                   owner;
    logic                   grant0, grant1;
    logic [OP_WIDTH-1:0]    alu_op_q;
    logic [DATA_WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [SHAMT_WIDTH-1:0] alu_shamt_q;
    logic [DATA_WIDTH-1:0]  rsp_result_q;
    logic                   rsp_zero_q, rsp_err_q, busy_q;
    logic                   owner_ready;

    assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        next_state = state;
        // Grants are masked during reset so nothing is accepted while the FSM is being cleared.
        if (state == IDLE && reset) begin
            if (!rr_ptr) begin
                grant0 = bus.req0_valid;
                grant1 = !bus.req0_valid && bus.req1_valid;
            end else begin
                grant1 = bus.req1_valid;
                grant0 = !bus.req1_valid && bus.req0_valid;
            end
        end
        case (state)
            IDLE:    if (grant0 || grant1) next_state = ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    if (owner_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shamt_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
            if (grant0) begin
                alu_op_q    <= bus.req0_op;
                alu_a_q     <= bus.req0_a;
                alu_b_q     <= bus.req0_b;
                alu_shamt_q <= bus.req0_shamt;
                owner       <= 1'b0;
                rr_ptr      <= 1'b1;
            end else if (grant1) begin
                alu_op_q    <= bus.req1_op;
                alu_a_q     <= bus.req1_a;
                alu_b_q     <= bus.req1_b;
                alu_shamt_q <= bus.req1_shamt;
                owner       <= 1'b1;
                rr_ptr      <= 1'b0;
            end
            if (state == ISSUE) begin
                // Opcodes above 7 are not ALU operations; report a clean zero result instead.
                if (alu_op_q > OP_WIDTH'(7)) begin
                    rsp_result_q <= '0;
                    rsp_zero_q   <= 1'b1;
                    rsp_err_q    <= 1'b1;
                end else begin
                    rsp_result_q <= bus.alu_result;
                    rsp_zero_q   <= bus.alu_zero;
                    rsp_err_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_shamt  = alu_shamt_q;
    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) && owner;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, expected responses queued at accept
// time and compared in order when a response appears.
module tb_alu_arbiter;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic        owner;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT; others fall back to ADD.
    always_comb begin
        logic [31:0] r;
        case (bus.alu_op)
            4'd0:    r = bus.alu_a + bus.alu_b;
            4'd1:    r = bus.alu_a - bus.alu_b;
            4'd2:    r = bus.alu_a & bus.alu_b;
            4'd3:    r = bus.alu_a | bus.alu_b;
            4'd4:    r = bus.alu_a ^ bus.alu_b;
            4'd5:    r = bus.alu_a << bus.alu_shamt;
            4'd6:    r = bus.alu_a >> bus.alu_shamt;
            4'd7:    r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: r = bus.alu_a + bus.alu_b;
        endcase
        bus.alu_result = r;
        bus.alu_zero   = (r == 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic owner, input logic [31:0] result, input logic zero, input logic err);
        exp_t e;
        e.owner  = owner;
        e.result = result;
        e.zero   = zero;
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic drive0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] shamt);
        bus.req0_valid = 1'b1;
        bus.req0_op    = op;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_shamt = shamt;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] shamt);
        bus.req1_valid = 1'b1;
        bus.req1_op    = op;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_shamt = shamt;
    endtask

    // Waits (bounded) for a response, compares it against the scoreboard head, then consumes it.
    task automatic serve(input int budget);
        exp_t e;
        int   n = 0;
        while (!(bus.rsp0_valid || bus.rsp1_valid) && n < budget) begin
            step();
            n++;
        end
        check("rsp_timeout", 32'(bus.rsp0_valid || bus.rsp1_valid), 32'd1);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_owner", 32'(bus.rsp1_valid), 32'(e.owner));
            check("rsp_both_valid", 32'(bus.rsp0_valid && bus.rsp1_valid), 32'd0);
            check("rsp_result", bus.rsp_result, e.result);
            check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            if (e.owner) bus.rsp1_ready = 1'b1;
            else         bus.rsp0_ready = 1'b1;
        end
        step();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        check("rsp_released", 32'(bus.rsp0_valid || bus.rsp1_valid), 32'd0);
    endtask

    initial begin
        // Reset held with both requesters valid
        reset          = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        drive0(4'd0, 32'h1234, 32'h1, 5'd3);
        drive1(4'd1, 32'h5678, 32'h2, 5'd7);
        repeat (3) begin
            step();
            check("rst_ready0", 32'(bus.req0_ready), 32'd0);
            check("rst_ready1", 32'(bus.req1_ready), 32'd0);
            check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
            check("rst_alu_a", bus.alu_a, 32'd0);
            check("rst_alu_op", 32'(bus.alu_op), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset          = 1'b1;
        step();

        // Single ADD from requester 0 with latency check
        drive0(4'd0, 32'd5, 32'd7, 5'd0);
        #1;
        check("t2_ready0", 32'(bus.req0_ready), 32'd1);
        check("t2_ready1", 32'(bus.req1_ready), 32'd0);
        push(1'b0, 32'd12, 1'b0, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        check("t2_issue_busy", 32'(bus.busy), 32'd1);
        check("t2_issue_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check("t2_alu_a", bus.alu_a, 32'd5);
        check("t2_alu_b", bus.alu_b, 32'd7);
        step();
        check("t2_latency_rsp0", 32'(bus.rsp0_valid), 32'd1);
        serve(4);
        check("t2_idle_busy", 32'(bus.busy), 32'd0);

        // Contention from rr_ptr=0: requester 0, then 1, then 0 again
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive0(4'd1, 32'd9, 32'd9, 5'd0);
        drive1(4'd3, 32'hF0, 32'h0F, 5'd0);
        #1;
        check("t3a_ready0", 32'(bus.req0_ready), 32'd1);
        check("t3a_ready1", 32'(bus.req1_ready), 32'd0);
        push(1'b0, 32'd0, 1'b1, 1'b0);
        step();
        drive0(4'd4, 32'hAA, 32'hA5, 5'd0);
        #1;
        check("t3_issue_ready0", 32'(bus.req0_ready), 32'd0);
        check("t3_issue_ready1", 32'(bus.req1_ready), 32'd0);
        serve(4);
        check("t3b_ready1", 32'(bus.req1_ready), 32'd1);
        check("t3b_ready0", 32'(bus.req0_ready), 32'd0);
        push(1'b1, 32'hFF, 1'b0, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        serve(4);
        check("t3c_ready0", 32'(bus.req0_ready), 32'd1);
        push(1'b0, 32'h0F, 1'b0, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        serve(4);

        // Backpressure on requester 1 while requester 0 waits with an illegal op
        drive1(4'd5, 32'd1, 32'd0, 5'd4);
        #1;
        check("t4_ready1", 32'(bus.req1_ready), 32'd1);
        push(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        drive0(4'b1010, 32'd3, 32'd4, 5'd0);
        step();
        repeat (10) begin
            check("t4_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            check("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            check("t4_result", bus.rsp_result, 32'h10);
            check("t4_ready0", 32'(bus.req0_ready), 32'd0);
            check("t4_ready1", 32'(bus.req1_ready), 32'd0);
            check("t4_busy", 32'(bus.busy), 32'd1);
            step();
        end
        serve(2);

        // Illegal opcode from requester 0
        check("t5_ready0", 32'(bus.req0_ready), 32'd1);
        push(1'b0, 32'd0, 1'b1, 1'b1);
        step();
        bus.req0_valid = 1'b0;
        serve(4);

        // Reset during ISSUE aborts and clears rr_ptr
        drive0(4'd0, 32'd1, 32'd1, 5'd0);
        #1;
        check("t6a_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        check("t6a_issue_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t6a_busy", 32'(bus.busy), 32'd0);
        step();
        check("t6a_no_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check("t6a_no_rsp1", 32'(bus.rsp1_valid), 32'd0);
        check("t6a_alu_a", bus.alu_a, 32'd0);
        drive0(4'd0, 32'd2, 32'd3, 5'd0);
        drive1(4'd0, 32'd4, 32'd4, 5'd0);
        #1;
        check("t6a_tie_ready0", 32'(bus.req0_ready), 32'd1);
        check("t6a_tie_ready1", 32'(bus.req1_ready), 32'd0);
        push(1'b0, 32'd5, 1'b0, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        serve(4);
        check("t6a_next_ready1", 32'(bus.req1_ready), 32'd1);
        push(1'b1, 32'd8, 1'b0, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        serve(4);

        // Reset during RESP drops the pending response and clears rr_ptr
        drive0(4'd0, 32'd6, 32'd6, 5'd0);
        #1;
        check("t6b_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        step();
        check("t6b_resp_rsp0", 32'(bus.rsp0_valid), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t6b_no_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check("t6b_busy", 32'(bus.busy), 32'd0);
        drive0(4'd0, 32'd1, 32'd2, 5'd0);
        drive1(4'd0, 32'd3, 32'd3, 5'd0);
        #1;
        check("t6b_tie_ready0", 32'(bus.req0_ready), 32'd1);
        check("t6b_tie_ready1", 32'(bus.req1_ready), 32'd0);
        push(1'b0, 32'd3, 1'b0, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        serve(4);
        check("t6b_next_ready1", 32'(bus.req1_ready), 32'd1);
        push(1'b1, 32'd6, 1'b0, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        serve(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
